// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the processor datapath.
// master = sequencer (drives strobes/selects), slave = datapath (drives IR fields and ALU flags).
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             ZF;
    logic             OF;
    logic             PC_Write;
    logic [1:0]       PC_Src;
    logic             IR_Write;
    logic             Reg_Write;
    logic             RegDst;
    logic             MemToReg;
    logic             Mem_Write;
    logic             ALU_SrcA;
    logic [1:0]       ALU_SrcB;
    logic             ExtSel;
    logic [3:0]       ALU_OP;
    logic [3:0]       state;
    logic             halted;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  op, funct, ZF, OF,
        output PC_Write, PC_Src, IR_Write, Reg_Write, RegDst, MemToReg, Mem_Write,
               ALU_SrcA, ALU_SrcB, ExtSel, ALU_OP, state, halted, instr_cnt
    );

    modport slave (
        output op, funct, ZF, OF,
        input  PC_Write, PC_Src, IR_Write, Reg_Write, RegDst, MemToReg, Mem_Write,
               ALU_SrcA, ALU_SrcB, ExtSel, ALU_OP, state, halted, instr_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: IF/ID/EXE/MEM/WB, drives all datapath enables and selects.
// Latency 3-5 cycles per instruction; outputs registered except the branch PC_Write (follows ZF).
// No backpressure: advances every cycle, HALT holds until reset.
module multicycle_ctrl #(
    parameter int CNT_W           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        S_INIT = 4'd0,  S_IF = 4'd1,     S_ID = 4'd2,     S_EXE_R = 4'd3,
        S_EXE_I = 4'd4, S_EXE_LS = 4'd5, S_EXE_BR = 4'd6, S_EXE_J = 4'd7,
        S_MEM_RD = 4'd8, S_MEM_WR = 4'd9, S_WB_R = 4'd10, S_WB_I = 4'd11,
        S_WB_LD = 4'd12, S_HALT = 4'd15
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_XOR = 4'b0010,
                           ALU_NOR = 4'b0011, ALU_ADD = 4'b0100, ALU_SUB = 4'b0101,
                           ALU_SLT = 4'b0110, ALU_SLTU = 4'b0111;

    state_t           state_q, state_nxt;
    logic             ovf_q, ovf_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;

    logic             pc_write_q, ir_write_q, reg_write_q, mem_write_q;
    logic             reg_dst_q, mem_to_reg_q, src_a_q, ext_sel_q, halted_q;
    logic [1:0]       pc_src_q, src_b_q;
    logic [3:0]       alu_op_q;

    logic             r_type, funct_ok, r_ovf_chk;
    logic             is_itype, i_zext, is_ls, is_br, is_j, legal;
    logic [3:0]       r_alu, i_alu;

    always_comb begin
        funct_ok  = 1'b1;
        r_ovf_chk = 1'b0;
        r_alu     = ALU_ADD;
        case (bus.funct)
            6'b100000: begin r_alu = ALU_ADD; r_ovf_chk = 1'b1; end
            6'b100001: r_alu = ALU_ADD;
            6'b100010: begin r_alu = ALU_SUB; r_ovf_chk = 1'b1; end
            6'b100011: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b100110: r_alu = ALU_XOR;
            6'b100111: r_alu = ALU_NOR;
            6'b101010: r_alu = ALU_SLT;
            6'b101011: r_alu = ALU_SLTU;
            default:   funct_ok = 1'b0;
        endcase

        is_itype = 1'b1;
        i_zext   = 1'b0;
        i_alu    = ALU_ADD;
        case (bus.op)
            6'b001000: i_alu = ALU_ADD;
            6'b001010: i_alu = ALU_SLT;
            6'b001011: i_alu = ALU_SLTU;
            6'b001100: begin i_alu = ALU_AND; i_zext = 1'b1; end
            6'b001101: begin i_alu = ALU_OR;  i_zext = 1'b1; end
            6'b001110: begin i_alu = ALU_XOR; i_zext = 1'b1; end
            default:   is_itype = 1'b0;
        endcase

        r_type = (bus.op == 6'b000000);
        is_ls  = (bus.op == 6'b100011) || (bus.op == 6'b101011);
        is_br  = (bus.op == 6'b000100) || (bus.op == 6'b000101);
        is_j   = (bus.op == 6'b000010);
        legal  = (r_type && funct_ok) || is_itype || is_ls || is_br || is_j;
    end

    always_comb begin
        state_nxt = S_INIT;
        ovf_nxt   = ovf_q;
        case (state_q)
            S_INIT:   state_nxt = S_IF;
            S_IF:     begin state_nxt = S_ID; ovf_nxt = 1'b0; end
            S_ID: begin
                if (r_type && funct_ok) state_nxt = S_EXE_R;
                else if (is_itype)      state_nxt = S_EXE_I;
                else if (is_ls)         state_nxt = S_EXE_LS;
                else if (is_br)         state_nxt = S_EXE_BR;
                else if (is_j)          state_nxt = S_EXE_J;
                else                    state_nxt = HALT_ON_ILLEGAL ? S_HALT : S_IF;
            end
            S_EXE_R:  begin state_nxt = S_WB_R; ovf_nxt = bus.OF & r_ovf_chk; end
            S_EXE_I:  begin state_nxt = S_WB_I; ovf_nxt = bus.OF & (bus.op == 6'b001000); end
            S_EXE_LS: state_nxt = (bus.op == 6'b100011) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_nxt = S_WB_LD;
            S_EXE_BR, S_EXE_J, S_MEM_WR, S_WB_R, S_WB_I, S_WB_LD: state_nxt = S_IF;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_INIT;
        endcase

        retire = (state_q == S_WB_R) || (state_q == S_WB_I) || (state_q == S_WB_LD) ||
                 (state_q == S_MEM_WR) || (state_q == S_EXE_BR) || (state_q == S_EXE_J) ||
                 ((state_q == S_ID) && !legal && !HALT_ON_ILLEGAL);
    end

    // Outputs are decoded from the state being entered so they are registered alongside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_INIT;
            ovf_q        <= 1'b0;
            cnt_q        <= '0;
            pc_write_q   <= 1'b0;
            ir_write_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            src_a_q      <= 1'b0;
            ext_sel_q    <= 1'b0;
            halted_q     <= 1'b0;
            pc_src_q     <= 2'b00;
            src_b_q      <= 2'b00;
            alu_op_q     <= 4'b0000;
        end else begin
            state_q <= state_nxt;
            ovf_q   <= ovf_nxt;
            if (retire) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

            pc_write_q   <= 1'b0;
            ir_write_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            src_a_q      <= 1'b0;
            ext_sel_q    <= 1'b0;
            halted_q     <= 1'b0;
            pc_src_q     <= 2'b00;
            src_b_q      <= 2'b00;
            alu_op_q     <= 4'b0000;
            case (state_nxt)
                S_IF: begin
                    ir_write_q <= 1'b1;
                    pc_write_q <= 1'b1;
                    src_b_q    <= 2'b01;
                    alu_op_q   <= ALU_ADD;
                end
                S_ID: begin
                    src_b_q   <= 2'b11;
                    ext_sel_q <= 1'b1;
                    alu_op_q  <= ALU_ADD;
                end
                S_EXE_R: begin
                    src_a_q  <= 1'b1;
                    alu_op_q <= r_alu;
                end
                S_EXE_I: begin
                    src_a_q   <= 1'b1;
                    src_b_q   <= 2'b10;
                    ext_sel_q <= ~i_zext;
                    alu_op_q  <= i_alu;
                end
                S_EXE_LS: begin
                    src_a_q   <= 1'b1;
                    src_b_q   <= 2'b10;
                    ext_sel_q <= 1'b1;
                    alu_op_q  <= ALU_ADD;
                end
                S_EXE_BR: begin
                    src_a_q  <= 1'b1;
                    alu_op_q <= ALU_SUB;
                    pc_src_q <= 2'b01;
                end
                S_EXE_J: begin
                    pc_write_q <= 1'b1;
                    pc_src_q   <= 2'b10;
                end
                S_MEM_WR: mem_write_q <= 1'b1;
                S_WB_R: begin
                    reg_write_q <= ~ovf_nxt;
                    reg_dst_q   <= 1'b1;
                end
                S_WB_I:  reg_write_q <= ~ovf_nxt;
                S_WB_LD: begin
                    reg_write_q  <= 1'b1;
                    mem_to_reg_q <= 1'b1;
                end
                S_HALT:  halted_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // Branch decision must see this cycle's ZF; op[0] distinguishes bne from beq.
    assign bus.PC_Write  = pc_write_q | ((state_q == S_EXE_BR) & (bus.ZF ^ bus.op[0]));
    assign bus.PC_Src    = pc_src_q;
    assign bus.IR_Write  = ir_write_q;
    assign bus.Reg_Write = reg_write_q;
    assign bus.RegDst    = reg_dst_q;
    assign bus.MemToReg  = mem_to_reg_q;
    assign bus.Mem_Write = mem_write_q;
    assign bus.ALU_SrcA  = src_a_q;
    assign bus.ALU_SrcB  = src_b_q;
    assign bus.ExtSel    = ext_sel_q;
    assign bus.ALU_OP    = alu_op_q;
    assign bus.state     = state_q;
    assign bus.halted    = halted_q;
    assign bus.instr_cnt = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of instructions with per-cycle expectations fed through a
// scoreboard queue, plus hand sequences for halt, reset abort and NOP-retired illegal opcodes.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(32)) bus ();
    multicycle_ctrl_if #(.CNT_W(32)) bus2 ();

    multicycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
    multicycle_ctrl #(.CNT_W(32), .HALT_ON_ILLEGAL(1'b0)) dut_nop (.clk(clk), .rst(rst2), .bus(bus2));

    // stb = {PC_Write, IR_Write, Reg_Write, Mem_Write}; misc = {RegDst, MemToReg, SrcA, SrcB, ExtSel}
    typedef struct packed {
        logic [3:0]  st;
        logic [3:0]  stb;
        logic [5:0]  misc;
        logic [3:0]  alu;
        logic [1:0]  src;
        logic        halted;
        logic [31:0] cnt;
    } obs_t;

    typedef struct {
        string name;
        obs_t  o;
    } exp_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zf;
        logic       of;
        int         lat;
        logic [3:0] st[5];
        logic [3:0] stb[5];
        logic [5:0] misc[5];
        logic [3:0] alu3;
        logic [1:0] src3;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_cnt = 0;

    function automatic obs_t sample();
        obs_t o;
        o.st     = bus.state;
        o.stb    = {bus.PC_Write, bus.IR_Write, bus.Reg_Write, bus.Mem_Write};
        o.misc   = {bus.RegDst, bus.MemToReg, bus.ALU_SrcA, bus.ALU_SrcB, bus.ExtSel};
        o.alu    = bus.ALU_OP;
        o.src    = bus.PC_Src;
        o.halted = bus.halted;
        o.cnt    = bus.instr_cnt;
        return o;
    endfunction

    function automatic void add_vec(string n, logic [5:0] op, logic [5:0] funct, logic zf,
                                    logic of, int lat, logic [3:0] s3, logic [3:0] s4,
                                    logic [3:0] s5, logic [3:0] b3, logic [3:0] b4,
                                    logic [3:0] b5, logic [5:0] m3, logic [5:0] m4,
                                    logic [5:0] m5, logic [3:0] alu3, logic [1:0] src3);
        vec_t v;
        v.name = n; v.op = op; v.funct = funct; v.zf = zf; v.of = of; v.lat = lat;
        v.st[0] = 4'd1; v.stb[0] = 4'b1100; v.misc[0] = 6'b000010;
        v.st[1] = 4'd2; v.stb[1] = 4'b0000; v.misc[1] = 6'b000111;
        v.st[2] = s3;   v.stb[2] = b3;      v.misc[2] = m3;
        v.st[3] = s4;   v.stb[3] = b4;      v.misc[3] = m4;
        v.st[4] = s5;   v.stb[4] = b5;      v.misc[4] = m5;
        v.alu3 = alu3; v.src3 = src3;
        vecs.push_back(v);
    endfunction

    task automatic push(string n, logic [3:0] st, logic [3:0] stb, logic [5:0] misc,
                        logic [3:0] alu, logic [1:0] src, logic h);
        exp_t e;
        e.name     = n;
        e.o.st     = st;
        e.o.stb    = stb;
        e.o.misc   = misc;
        e.o.alu    = alu;
        e.o.src    = src;
        e.o.halted = h;
        e.o.cnt    = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        obs_t g;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_underflow at %0t", $time);
        end else begin
            e = sb.pop_front();
            g = sample();
            if (g !== e.o)
                begin
                    fails++;
                    $display("FAIL %s: got st=%0d stb=%b misc=%b alu=%b src=%b halt=%b cnt=%0d, want st=%0d stb=%b misc=%b alu=%b src=%b halt=%b cnt=%0d",
                             e.name, g.st, g.stb, g.misc, g.alu, g.src, g.halted, g.cnt,
                             e.o.st, e.o.stb, e.o.misc, e.o.alu, e.o.src, e.o.halted, e.o.cnt);
                end
        end
    endtask

    task automatic chk(string n, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", n, got, want);
        end
    endtask

    task automatic run_vec(vec_t v);
        bus.op = v.op; bus.funct = v.funct; bus.ZF = v.zf; bus.OF = v.of;
        for (int c = 0; c < v.lat; c++)
            push($sformatf("%s/c%0d", v.name, c + 1), v.st[c], v.stb[c], v.misc[c],
                 (c < 2) ? 4'b0100 : ((c == 2) ? v.alu3 : 4'b0000),
                 (c == 2) ? v.src3 : 2'b00, 1'b0);
        for (int c = 0; c < v.lat; c++) begin
            @(negedge clk);
            check_pop();
        end
        exp_cnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t sw_v;
        //        name      op         funct      zf    of  lat st3 st4 st5 b3       b4       b5       m3         m4         m5         alu3     src3
        add_vec("add",    6'o00, 6'b100000, 1'b0, 1'b0, 4, 3, 10, 0, 4'b0000, 4'b0010, 4'b0000, 6'b001000, 6'b100000, 6'b000000, 4'b0100, 2'b00);
        add_vec("add_ovf",6'o00, 6'b100000, 1'b0, 1'b1, 4, 3, 10, 0, 4'b0000, 4'b0000, 4'b0000, 6'b001000, 6'b100000, 6'b000000, 4'b0100, 2'b00);
        add_vec("addu_of",6'o00, 6'b100001, 1'b0, 1'b1, 4, 3, 10, 0, 4'b0000, 4'b0010, 4'b0000, 6'b001000, 6'b100000, 6'b000000, 4'b0100, 2'b00);
        add_vec("sub_ovf",6'o00, 6'b100010, 1'b0, 1'b1, 4, 3, 10, 0, 4'b0000, 4'b0000, 4'b0000, 6'b001000, 6'b100000, 6'b000000, 4'b0101, 2'b00);
        add_vec("nor",    6'o00, 6'b100111, 1'b0, 1'b0, 4, 3, 10, 0, 4'b0000, 4'b0010, 4'b0000, 6'b001000, 6'b100000, 6'b000000, 4'b0011, 2'b00);
        add_vec("sltu",   6'o00, 6'b101011, 1'b0, 1'b0, 4, 3, 10, 0, 4'b0000, 4'b0010, 4'b0000, 6'b001000, 6'b100000, 6'b000000, 4'b0111, 2'b00);
        add_vec("addi_of",6'b001000, 6'd0,  1'b0, 1'b1, 4, 4, 11, 0, 4'b0000, 4'b0000, 4'b0000, 6'b001101, 6'b000000, 6'b000000, 4'b0100, 2'b00);
        add_vec("ori_of", 6'b001101, 6'd0,  1'b0, 1'b1, 4, 4, 11, 0, 4'b0000, 4'b0010, 4'b0000, 6'b001100, 6'b000000, 6'b000000, 4'b0001, 2'b00);
        add_vec("slti",   6'b001010, 6'd0,  1'b0, 1'b0, 4, 4, 11, 0, 4'b0000, 4'b0010, 4'b0000, 6'b001101, 6'b000000, 6'b000000, 4'b0110, 2'b00);
        add_vec("xori",   6'b001110, 6'd0,  1'b0, 1'b0, 4, 4, 11, 0, 4'b0000, 4'b0010, 4'b0000, 6'b001100, 6'b000000, 6'b000000, 4'b0010, 2'b00);
        add_vec("lw",     6'b100011, 6'd0,  1'b0, 1'b0, 5, 5, 8, 12, 4'b0000, 4'b0000, 4'b0010, 6'b001101, 6'b000000, 6'b010000, 4'b0100, 2'b00);
        add_vec("sw",     6'b101011, 6'd0,  1'b0, 1'b0, 4, 5, 9, 0,  4'b0000, 4'b0001, 4'b0000, 6'b001101, 6'b000000, 6'b000000, 4'b0100, 2'b00);
        add_vec("beq_t",  6'b000100, 6'd0,  1'b1, 1'b0, 3, 6, 0, 0,  4'b1000, 4'b0000, 4'b0000, 6'b001000, 6'b000000, 6'b000000, 4'b0101, 2'b01);
        add_vec("beq_nt", 6'b000100, 6'd0,  1'b0, 1'b0, 3, 6, 0, 0,  4'b0000, 4'b0000, 4'b0000, 6'b001000, 6'b000000, 6'b000000, 4'b0101, 2'b01);
        add_vec("bne_t",  6'b000101, 6'd0,  1'b0, 1'b0, 3, 6, 0, 0,  4'b1000, 4'b0000, 4'b0000, 6'b001000, 6'b000000, 6'b000000, 4'b0101, 2'b01);
        add_vec("bne_nt", 6'b000101, 6'd0,  1'b1, 1'b0, 3, 6, 0, 0,  4'b0000, 4'b0000, 4'b0000, 6'b001000, 6'b000000, 6'b000000, 4'b0101, 2'b01);
        add_vec("j",      6'b000010, 6'd0,  1'b0, 1'b0, 3, 7, 0, 0,  4'b1000, 4'b0000, 4'b0000, 6'b000000, 6'b000000, 6'b000000, 4'b0000, 2'b10);
        sw_v = vecs[0];
        foreach (vecs[i]) if (vecs[i].name == "sw") sw_v = vecs[i];

        bus.op = 6'd0; bus.funct = 6'd0; bus.ZF = 1'b0; bus.OF = 1'b0;
        bus2.op = 6'd0; bus2.funct = 6'd0; bus2.ZF = 1'b0; bus2.OF = 1'b0;

        #2 rst = 1'b0; rst2 = 1'b0;
        repeat (2) begin
            push("reset", 4'd0, 4'b0000, 6'd0, 4'd0, 2'd0, 1'b0);
            @(negedge clk);
            check_pop();
        end
        rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Illegal opcode: HALT with no strobes, counter frozen.
        bus.op = 6'b111111; bus.funct = 6'd0;
        push("ill/IF", 4'd1, 4'b1100, 6'b000010, 4'b0100, 2'b00, 1'b0);
        push("ill/ID", 4'd2, 4'b0000, 6'b000111, 4'b0100, 2'b00, 1'b0);
        for (int i = 0; i < 10; i++)
            push($sformatf("halt%0d", i), 4'd15, 4'b0000, 6'd0, 4'd0, 2'd0, 1'b1);
        repeat (12) begin
            @(negedge clk);
            check_pop();
        end

        // Asynchronous reset out of HALT.
        rst = 1'b0;
        #1;
        exp_cnt = 0;
        push("halt_rst", 4'd0, 4'b0000, 6'd0, 4'd0, 2'd0, 1'b0);
        check_pop();
        @(negedge clk);
        rst = 1'b1;
        run_vec(vecs[0]);

        // Reset during IF drops IR_Write/PC_Write at once.
        bus.op = 6'b101011;
        push("abort_if/IF", 4'd1, 4'b1100, 6'b000010, 4'b0100, 2'b00, 1'b0);
        @(negedge clk);
        check_pop();
        rst = 1'b0;
        #1;
        exp_cnt = 0;
        push("abort_if/rst", 4'd0, 4'b0000, 6'd0, 4'd0, 2'd0, 1'b0);
        check_pop();

        // Reset in EXE_LS of sw: the MEM_WR strobe must never appear.
        @(negedge clk);
        rst = 1'b1;
        push("abort_sw/IF", 4'd1, 4'b1100, 6'b000010, 4'b0100, 2'b00, 1'b0);
        push("abort_sw/ID", 4'd2, 4'b0000, 6'b000111, 4'b0100, 2'b00, 1'b0);
        push("abort_sw/LS", 4'd5, 4'b0000, 6'b001101, 4'b0100, 2'b00, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_pop();
        end
        rst = 1'b0;
        push("abort_sw/held", 4'd0, 4'b0000, 6'd0, 4'd0, 2'd0, 1'b0);
        @(negedge clk);
        check_pop();
        rst = 1'b1;
        run_vec(sw_v);

        // HALT_ON_ILLEGAL=0: illegal op retires as a NOP from ID.
        bus2.op = 6'b111111;
        rst2 = 1'b1;
        @(negedge clk);
        chk("nop/c1_state", 32'(bus2.state), 32'd1);
        chk("nop/c1_irw", 32'(bus2.IR_Write), 32'd1);
        chk("nop/c1_cnt", bus2.instr_cnt, 32'd0);
        @(negedge clk);
        chk("nop/c2_state", 32'(bus2.state), 32'd2);
        @(negedge clk);
        chk("nop/c3_state", 32'(bus2.state), 32'd1);
        chk("nop/c3_halted", 32'(bus2.halted), 32'd0);
        chk("nop/c3_cnt", bus2.instr_cnt, 32'd1);
        repeat (2) @(negedge clk);
        chk("nop/c5_cnt", bus2.instr_cnt, 32'd2);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
